// File: rtl/mul_norm_seq.sv
// Multi-cycle normalisation sequencer for the FP multiplier back end.
// Takes the raw product mantissa and the biased exponent sum. It shifts the mantissa left to
// normalise it, or right to denormalise it, by at most STEP bits per cycle. The result goes to
// the rounder with the final exponent and a sticky bit.
// Optional feature macro: MUL_NORM_SEQ_STICKY_EN. When it is defined, out_sticky_o accumulates
// the OR of the bits dropped by right shifts. When it is undefined, out_sticky_o is tied to 0.
module mul_norm_seq #(
  parameter int unsigned EXPO_W = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned ZERO_D = 6,
  parameter int unsigned STEP   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXPO_W+1:0]      in_expo_i,
  input  logic [2*MANT_W+1:0]    in_mant_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*MANT_W+1:0]    out_mant_o,
  output logic [EXPO_W-1:0]      out_expo_o,
  output logic                   out_sticky_o,
  output logic                   out_ovf_o
);

  localparam int unsigned PROD_W = 2 * MANT_W + 2;
  localparam int unsigned EXPW2  = EXPO_W + 2;
  localparam int unsigned CNT_W  = ZERO_D + 1;

  localparam logic [CNT_W-1:0]        MaxShift = CNT_W'(PROD_W - 1);
  localparam logic [CNT_W-1:0]        StepCnt  = CNT_W'(STEP);
  localparam logic signed [EXPW2-1:0] OvfLim   = EXPW2'((1 << EXPO_W) - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [PROD_W-1:0] mant_q, mant_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic [CNT_W-1:0]  shifted_q, shifted_d;
  logic [EXPW2-1:0]  expo_q, expo_d;
  logic              left_q, left_d;
  logic              ovf_q, ovf_d;
  logic [EXPO_W-1:0] out_expo_q, out_expo_d;

  // Accept-time classification
  logic             accept;
  logic             acc_ovf, acc_zero, acc_left, acc_skip;
  logic [CNT_W-1:0] acc_budget;

  // One SHIFT step
  logic [STEP-1:0]   top_bits;
  logic              top_seen;
  logic [CNT_W-1:0]  top_lzc;
  logic [CNT_W-1:0]  step_amt;
  logic [PROD_W-1:0] mant_left, mant_right, mant_step;
  logic [CNT_W-1:0]  budget_step, shifted_step;
  logic [EXPW2-1:0]  left_expo;
  logic              step_exit;

  // Any difference with bits above ZERO_D set, or beyond the product width, caps the shift.
  function automatic logic [CNT_W-1:0] sat_shift(input logic [EXPW2-1:0] diff);
    logic [CNT_W-1:0] low;
    low = diff[CNT_W-1:0];
    if (((diff >> CNT_W) != '0) || (low > MaxShift)) begin
      return MaxShift;
    end
    return low;
  endfunction

  assign accept = (state_q == StIdle) && in_valid_i;

  // Classify the incoming operands and derive the saturated shift budget
  always_comb begin
    acc_ovf  = $signed(in_expo_i) >= OvfLim;
    acc_zero = (in_mant_i == '0);
    acc_left = !in_expo_i[EXPW2-1] && (in_expo_i != '0);
    if (acc_left) begin
      acc_budget = sat_shift(in_expo_i - EXPW2'(1));
    end else begin
      acc_budget = sat_shift(EXPW2'(1) - in_expo_i);
    end
    // No SHIFT cycles when nothing is to be shifted or the mantissa is already normalised.
    acc_skip = acc_ovf || acc_zero || (acc_budget == '0) || (acc_left && in_mant_i[PROD_W-1]);
  end

  // Compute the result of one narrow shift step from the current working registers
  always_comb begin
    top_bits = mant_q[PROD_W-1 -: STEP];
    top_seen = 1'b0;
    top_lzc  = '0;
    for (int i = 0; i < int'(STEP); i++) begin
      top_seen = top_seen | top_bits[STEP-1];
      if (!top_seen) begin
        top_lzc = top_lzc + CNT_W'(1);
      end
      top_bits = top_bits << 1;
    end
    if (left_q) begin
      step_amt = (top_lzc < budget_q) ? top_lzc : budget_q;
    end else begin
      step_amt = (StepCnt < budget_q) ? StepCnt : budget_q;
    end
    mant_left    = mant_q << step_amt;
    mant_right   = mant_q >> step_amt;
    mant_step    = left_q ? mant_left : mant_right;
    budget_step  = budget_q - step_amt;
    shifted_step = shifted_q + step_amt;
    left_expo    = expo_q - EXPW2'(shifted_step);
    step_exit    = (budget_step == '0) || (left_q && mant_left[PROD_W-1]);
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = acc_skip ? StDone : StShift;
        end
      end
      StShift: begin
        if (step_exit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: handshake flags decoded from the state
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
  end

  // Datapath next-state: load on accept, advance one step per SHIFT cycle, hold otherwise
  always_comb begin
    mant_d     = mant_q;
    budget_d   = budget_q;
    shifted_d  = shifted_q;
    expo_d     = expo_q;
    left_d     = left_q;
    ovf_d      = ovf_q;
    out_expo_d = out_expo_q;
    if (accept) begin
      mant_d    = in_mant_i;
      budget_d  = acc_budget;
      shifted_d = '0;
      expo_d    = in_expo_i;
      left_d    = acc_left;
      ovf_d     = acc_ovf;
      if (acc_ovf) begin
        out_expo_d = '1;
      end else if (acc_left && in_mant_i[PROD_W-1]) begin
        out_expo_d = in_expo_i[EXPO_W-1:0];
      end else begin
        out_expo_d = '0;
      end
    end else if (state_q == StShift) begin
      mant_d    = mant_step;
      budget_d  = budget_step;
      shifted_d = shifted_step;
      // Only a normalised left result keeps a non-zero exponent.
      if (left_q && mant_left[PROD_W-1]) begin
        out_expo_d = left_expo[EXPO_W-1:0];
      end else begin
        out_expo_d = '0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mant_q     <= '0;
      budget_q   <= '0;
      shifted_q  <= '0;
      expo_q     <= '0;
      left_q     <= 1'b0;
      ovf_q      <= 1'b0;
      out_expo_q <= '0;
    end else begin
      mant_q     <= mant_d;
      budget_q   <= budget_d;
      shifted_q  <= shifted_d;
      expo_q     <= expo_d;
      left_q     <= left_d;
      ovf_q      <= ovf_d;
      out_expo_q <= out_expo_d;
    end
  end

`ifdef MUL_NORM_SEQ_STICKY_EN
  logic [PROD_W-1:0] drop_mask;
  logic              dropped;
  logic              sticky_q, sticky_d;

  // Collect the bits a right step pushes off the bottom of the mantissa
  always_comb begin
    drop_mask = ~({PROD_W{1'b1}} << step_amt);
    dropped   = |(mant_q & drop_mask);
    sticky_d  = sticky_q;
    if (accept) begin
      sticky_d = 1'b0;
    end else if ((state_q == StShift) && !left_q) begin
      sticky_d = sticky_q | dropped;
    end
  end

  // Sticky register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign out_sticky_o = sticky_q;
`else
  assign out_sticky_o = 1'b0;
`endif

  assign out_mant_o = mant_q;
  assign out_expo_o = out_expo_q;
  assign out_ovf_o  = ovf_q;

endmodule

// File: tb/tb_mul_norm_seq.sv
// Self-checking bench for mul_norm_seq (EXPO_W=8, MANT_W=23, STEP=4).
// A reference model works from whole-operation arithmetic: leading-zero count, min/max
// and a single shift. It predicts the mantissa, exponent, sticky, overflow and latency.
module tb_mul_norm_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_expo = '0;
  logic [47:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] out_mant;
  logic [7:0]  out_expo;
  logic        out_sticky;
  logic        out_ovf;

  int tests = 0;
  int failed = 0;

  mul_norm_seq dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_expo_i   (in_expo),
    .in_mant_i   (in_mant),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_mant_o  (out_mant),
    .out_expo_o  (out_expo),
    .out_sticky_o(out_sticky),
    .out_ovf_o   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: total shift = min(leading zeros, expo-1, 47) to the left,
  // or min(1-expo, 47) to the right. SHIFT cycles = ceil(total/4).
  task automatic model(input int e, input logic [47:0] m, output logic [47:0] em,
                       output logic [7:0] ee, output logic es, output logic eo,
                       output int en);
    int          lz;
    int          amt;
    logic [47:0] tmp;
    em = m;
    ee = '0;
    es = 1'b0;
    eo = 1'b0;
    en = 0;
    if (e >= 255) begin
      eo = 1'b1;
    end else if (m == '0) begin
      em = '0;
    end else if (e >= 1) begin
      lz  = 0;
      tmp = m;
      while (!tmp[47]) begin
        tmp = tmp << 1;
        lz++;
      end
      amt = e - 1;
      if (amt > 47) amt = 47;
      if (lz < amt) amt = lz;
      em = m << amt;
      ee = em[47] ? 8'(e - amt) : 8'd0;
      en = (amt + 3) / 4;
    end else begin
      amt = 1 - e;
      if (amt > 47) amt = 47;
      em = m >> amt;
`ifdef MUL_NORM_SEQ_STICKY_EN
      es = ((m & ((48'd1 << amt) - 48'd1)) != '0);
`endif
      en = (amt + 3) / 4;
    end
  endtask

  task automatic run_job(input string name, input int e, input logic [47:0] m, input int hold);
    logic [47:0] em;
    logic [7:0]  ee;
    logic        es;
    logic        eo;
    int          en;
    int          cnt;
    model(e, m, em, ee, es, eo, en);
    @(negedge clk);
    chk({name, "/in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_expo  = 10'(e);
    in_mant  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_expo  = '0;
    in_mant  = '0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 100);
    chk({name, "/latency"}, cnt, 1 + en);
    chk({name, "/mant"}, out_mant, em);
    chk({name, "/ovf"}, out_ovf, eo);
    chk({name, "/sticky"}, out_sticky, es);
    if (!eo) chk({name, "/expo"}, out_expo, ee);
    chk({name, "/in_ready_busy"}, in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_expo  = 10'($urandom);
      in_mant  = 48'({$urandom, $urandom});
      @(negedge clk);
      chk({name, "/hold_valid"}, out_valid, 1);
      chk({name, "/hold_mant"}, out_mant, em);
      chk({name, "/hold_sticky"}, out_sticky, es);
      chk({name, "/hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "/release_valid"}, out_valid, 0);
    chk({name, "/release_in_ready"}, in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    int          e;
    logic [47:0] m;
    logic        seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset/in_ready", in_ready, 1);
    chk("reset/out_valid", out_valid, 0);
    chk("reset/out_mant", out_mant, 0);
    chk("reset/out_expo", out_expo, 0);
    chk("reset/out_ovf", out_ovf, 0);
    chk("reset/out_sticky", out_sticky, 0);
    rst_n = 1'b1;

    // Directed cases
    run_job("t1_norm", 127, 48'h800000000000, 0);
    run_job("t2_left", 10, 48'd1 << 40, 0);
    run_job("t3_budget", 3, 48'd1 << 30, 0);
    run_job("t4_right", -5, 48'h800000000001, 0);
    run_job("t5_sat", -100, 48'h800000000001, 0);
    run_job("t5_ovf", 255, 48'h123456789abc, 0);
    run_job("ovf_max", 511, 48'h000000000001, 0);
    run_job("zero_mant", 50, 48'h0, 0);
    run_job("expo_one", 1, 48'h000000ffffff, 0);
    run_job("expo_zero", 0, 48'h000000000003, 0);
    run_job("expo_min", -512, 48'hffffffffffff, 0);
    run_job("left_sat", 200, 48'h000000000001, 0);
    run_job("t6_hold", 20, 48'h000012345678, 5);

    // Reset in the middle of a long right shift
    @(negedge clk);
    in_valid = 1'b1;
    in_expo  = 10'(-100);
    in_mant  = 48'h800000000001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst/busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst/out_valid", out_valid, 0);
    chk("midrst/in_ready", in_ready, 1);
    chk("midrst/out_mant", out_mant, 0);
    chk("midrst/out_sticky", out_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst/no_result", seen, 0);
    run_job("after_rst", 10, 48'd1 << 40, 0);

    // Randomised jobs, mostly around the interesting exponent range
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 1023)) - 512;
      else e = int'($urandom_range(0, 120)) - 60;
      m = 48'({$urandom, $urandom});
      m = m >> $urandom_range(0, 47);
      if ($urandom_range(0, 15) == 0) m = '0;
      run_job("rand", e, m, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
